alien_swarm_ctrl: RTL
=====================

Name: alien_swarm_ctrl

Overview:
Autonomous controller for the invader formation: owns the alive mask, swarm origin and march direction, and paces motion from a frame tick.
- March speeds up as aliens die.
- Resolves laser hits, reporting at most one kill per cycle with its index.
- Flags victory and defeat.
- Sits between the laser controller, the game FSM and the sprite renderer.

Parameters:
NB_LIN, 5, formation rows
NB_COL, 11, formation columns
ALIEN_W, 20, sprite width (px)
ALIEN_H, 10, sprite height (px)
GAP_H, 20, horizontal gap between sprites
GAP_V, 10, vertical gap between sprites
STEP_X, 4, horizontal step per march (px)
STEP_Y, 10, drop per edge reversal (px)
X0, 40, reset swarm origin x
Y0, 40, reset swarm origin y
SCREEN_W, 640, screen width
SCREEN_H, 480, screen height
MARGIN, 5, side margin
LIMIT_BOTTOM, 40, defeat line distance from bottom
PERIOD_MAX, 32, ticks per step with full swarm
PERIOD_MIN, 2, fastest ticks per step
PERIOD_DEC, 1, period reduction per kill

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame pulse
start  in  1  leave IDLE, begin march
laser_valid  in  1  laser coordinates valid this cycle
x_laser  in  10  laser x
y_laser  in  10  laser y
kill  out  1  one-cycle pulse, alien destroyed
kill_idx  out  clog2(NB_LIN*NB_COL)  index (row*NB_COL+col) of destroyed alien
alive  out  NB_LIN*NB_COL  alive mask, bit row*NB_COL+col
x_alien  out  11 signed  swarm origin x
y_alien  out  10  swarm origin y
dir_left  out  1  0 = marching right, 1 = left
victory  out  1  level, all aliens dead
defeat  out  1  level, swarm reached defeat line

Behaviour:
- Reset, async: alive all ones (exact width, no constant truncation), x_alien=X0, y_alien=Y0, dir_left=0, tick counter 0, kill=0, kill_idx=0, victory=0, defeat=0, state IDLE. Reset asserted mid-march wins immediately.
- Alien (r,c) box: x in [x_alien+c*(ALIEN_W+GAP_H), +ALIEN_W), y in [y_alien+r*(ALIEN_H+GAP_V), +ALIEN_H). Half-open on both axes.
- All position arithmetic is done in 12-bit signed.
- FSM states:
  - IDLE: frozen; start goes to MARCH.
  - MARCH: normal play.
  - WON, LOST: terminal, frozen until reset. Victory/defeat levels held.
- Extents (combinational from alive): leftmost live column Lc, rightmost live column Rc, bottom live row Br. Each is a priority encode over the column/row OR of alive.
- Pacing:
  - In MARCH, each tick increments the counter.
  - When counter+1 reaches P, the counter clears and one step executes on that cycle's clock edge.
  - P = max(PERIOD_MIN, PERIOD_MAX - kills*PERIOD_DEC), where kills is the count of dead aliens.
- Step right:
  - If right edge + STEP_X <= SCREEN_W-MARGIN: x_alien += STEP_X.
  - Else: y_alien += STEP_Y, dir_left=1, x unchanged.
  - Step left is symmetric, using left edge - STEP_X >= MARGIN.
- Hit detection:
  - Active only in MARCH with laser_valid.
  - Lowest-index live alien whose box contains the laser wins.
  - Next edge: kill=1 for exactly one cycle, kill_idx=index, alive bit cleared.
  - No hit means kill=0. kill_idx holds its last value.
- Simultaneous hit and step: the step uses pre-kill extents and position; the hit is tested against pre-step position.
- Victory: when alive becomes 0, victory=1 and state goes to WON on the following edge. Victory has priority over defeat in the same cycle.
- Defeat: when y_alien + Br*(ALIEN_H+GAP_V) + ALIEN_H > SCREEN_H-LIMIT_BOTTOM, defeat=1 and state goes to LOST. No further steps or kills.
- Ticks are ignored outside MARCH.

Decomposition:
- Shared package swarm_pkg: state enum (IDLE, MARCH, WON, LOST), pitch constants ALIEN_W+GAP_H and ALIEN_H+GAP_V, index width function.
- One sub-module, swarm_extents: combinational Lc/Rc/Br priority encoders and kill count from alive. Reused by the renderer.

Test Plan:
(All with NB_LIN=2, NB_COL=3, SCREEN_W=150, PERIOD_MAX=2, PERIOD_MIN=1.)
- Reset -> alive=6'b111111, x_alien=40, y_alien=40, dir_left=0, kill/victory/defeat=0, state IDLE; ticks in IDLE -> no motion.
- start, then 2 ticks -> x_alien=44 after second tick; right edge 144.
- Next period (2 ticks) at x=44 -> 148>145, so y_alien=50, dir_left=1, x_alien=44.
- laser_valid (45,51) during MARCH -> kill=1 for one cycle, kill_idx=0, alive=6'b111110; then P=1, so every tick steps.
- Laser at (60,45), in the gap -> no kill. Laser on the shared boundary x=80 -> hits column 1 only.
- Kill all six -> victory=1, state WON, ticks cause no motion; assert reset mid-WON -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/swarm_pkg.sv
// Shared types and constants for the invader formation controller.
// Imported by the controller, its interface and the extents encoder.
package swarm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARCH,
        S_WON,
        S_LOST
    } swarm_state_t;

    // Default sprite geometry and the resulting grid pitch.
    localparam int ALIEN_W_DEF = 20;
    localparam int ALIEN_H_DEF = 10;
    localparam int GAP_H_DEF   = 20;
    localparam int GAP_V_DEF   = 10;
    localparam int PITCH_X     = ALIEN_W_DEF + GAP_H_DEF;
    localparam int PITCH_Y     = ALIEN_H_DEF + GAP_V_DEF;

    // Width of all signed position arithmetic.
    localparam int POS_W = 12;
    typedef logic signed [POS_W-1:0] pos_t;

    // Bits needed to index n items (at least one).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alien_swarm_ctrl_if.sv
// Bundle between the swarm controller and its neighbours:
// laser/game inputs in, formation state and events out.
interface alien_swarm_ctrl_if
    import swarm_pkg::*;
#(
    parameter int NB_LIN = 5,
    parameter int NB_COL = 11
) ();

    localparam int N  = NB_LIN * NB_COL;
    localparam int IW = idx_w(N);

    logic                tick;
    logic                start;
    logic                laser_valid;
    logic [9:0]          x_laser;
    logic [9:0]          y_laser;
    logic                kill;
    logic [IW-1:0]       kill_idx;
    logic [N-1:0]        alive;
    logic signed [10:0]  x_alien;
    logic [9:0]          y_alien;
    logic                dir_left;
    logic                victory;
    logic                defeat;

    modport master (
        output tick, start, laser_valid, x_laser, y_laser,
        input  kill, kill_idx, alive, x_alien, y_alien,
        input  dir_left, victory, defeat
    );

    modport slave (
        input  tick, start, laser_valid, x_laser, y_laser,
        output kill, kill_idx, alive, x_alien, y_alien,
        output dir_left, victory, defeat
    );

endinterface

// File: rtl/swarm_extents.sv
// Formation extents from the alive mask: leftmost/rightmost live
// column, bottom live row, dead count. Also used by the renderer.
module swarm_extents
    import swarm_pkg::*;
#(
    parameter  int NB_LIN = 5,
    parameter  int NB_COL = 11,
    localparam int N      = NB_LIN * NB_COL,
    localparam int CW     = idx_w(NB_COL),
    localparam int RW     = idx_w(NB_LIN),
    localparam int KW     = $clog2(N + 1)
) (
    input  logic [N-1:0]  alive_i,
    output logic [CW-1:0] lc_o,
    output logic [CW-1:0] rc_o,
    output logic [RW-1:0] br_o,
    output logic [KW-1:0] kills_o,
    output logic          any_o
);

    logic [NB_COL-1:0] col_or;
    logic [NB_LIN-1:0] row_or;

    // Fold the mask onto columns and rows.
    always_comb begin
        col_or = '0;
        row_or = '0;
        for (int r = 0; r < NB_LIN; r++) begin
            for (int c = 0; c < NB_COL; c++) begin
                if (alive_i[r*NB_COL+c]) begin
                    col_or[c] = 1'b1;
                    row_or[r] = 1'b1;
                end
            end
        end
    end

    // Priority encoders; all zero when nothing is alive.
    always_comb begin
        lc_o = '0;
        rc_o = '0;
        br_o = '0;
        for (int c = NB_COL - 1; c >= 0; c--) begin
            if (col_or[c]) lc_o = CW'(c);
        end
        for (int c = 0; c < NB_COL; c++) begin
            if (col_or[c]) rc_o = CW'(c);
        end
        for (int r = 0; r < NB_LIN; r++) begin
            if (row_or[r]) br_o = RW'(r);
        end
    end

    // Dead aliens drive the march speed-up.
    always_comb begin
        kills_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!alive_i[i]) kills_o = kills_o + KW'(1);
        end
    end

    assign any_o = |alive_i;

endmodule

// File: rtl/alien_swarm_ctrl.sv
// Invader formation controller: alive mask, origin, march pacing,
// laser hit resolution and win/lose detection.
module alien_swarm_ctrl
    import swarm_pkg::*;
#(
    parameter int NB_LIN       = 5,
    parameter int NB_COL       = 11,
    parameter int ALIEN_W      = ALIEN_W_DEF,
    parameter int ALIEN_H      = ALIEN_H_DEF,
    parameter int GAP_H        = GAP_H_DEF,
    parameter int GAP_V        = GAP_V_DEF,
    parameter int STEP_X       = 4,
    parameter int STEP_Y       = 10,
    parameter int X0           = 40,
    parameter int Y0           = 40,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int MARGIN       = 5,
    parameter int LIMIT_BOTTOM = 40,
    parameter int PERIOD_MAX   = 32,
    parameter int PERIOD_MIN   = 2,
    parameter int PERIOD_DEC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    alien_swarm_ctrl_if.slave bus
);

    localparam int N  = NB_LIN * NB_COL;
    localparam int IW = idx_w(N);
    localparam int CW = idx_w(NB_COL);
    localparam int RW = idx_w(NB_LIN);
    localparam int KW = $clog2(N + 1);
    localparam int TW = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX + 1) : 1;
    localparam int PX = ALIEN_W + GAP_H;
    localparam int PY = ALIEN_H + GAP_V;

    localparam pos_t PX_S   = pos_t'(PX);
    localparam pos_t PY_S   = pos_t'(PY);
    localparam pos_t AW_S   = pos_t'(ALIEN_W);
    localparam pos_t AH_S   = pos_t'(ALIEN_H);
    localparam pos_t SX_S   = pos_t'(STEP_X);
    localparam pos_t RLIM_S = pos_t'(SCREEN_W - MARGIN);
    localparam pos_t LLIM_S = pos_t'(MARGIN);
    localparam pos_t LINE_S = pos_t'(SCREEN_H - LIMIT_BOTTOM);

    swarm_state_t       state_q;
    logic [N-1:0]       alive_q;
    logic signed [10:0] x_q;
    logic [9:0]         y_q;
    logic               dir_q;
    logic [TW-1:0]      cnt_q;
    logic               kill_q;
    logic [IW-1:0]      kidx_q;
    logic               vic_q;
    logic               def_q;

    logic [CW-1:0] lc;
    logic [CW-1:0] rc;
    logic [RW-1:0] br;
    logic [KW-1:0] kills;
    logic          any_live;

    swarm_extents #(
        .NB_LIN (NB_LIN),
        .NB_COL (NB_COL)
    ) u_ext (
        .alive_i (alive_q),
        .lc_o    (lc),
        .rc_o    (rc),
        .br_o    (br),
        .kills_o (kills),
        .any_o   (any_live)
    );

    pos_t x12;
    pos_t y12;
    pos_t lx12;
    pos_t ly12;
    pos_t left_edge;
    pos_t right_edge;
    pos_t bottom;

    assign x12  = {x_q[10], x_q};
    assign y12  = {2'b00, y_q};
    assign lx12 = {2'b00, bus.x_laser};
    assign ly12 = {2'b00, bus.y_laser};

    assign left_edge  = x12 + pos_t'(lc) * PX_S;
    assign right_edge = x12 + pos_t'(rc) * PX_S + AW_S;
    assign bottom     = y12 + pos_t'(br) * PY_S + AH_S;

    logic over_line;
    logic can_right;
    logic can_left;

    assign over_line = bottom > LINE_S;
    assign can_right = (right_edge + SX_S) <= RLIM_S;
    assign can_left  = (left_edge - SX_S) >= LLIM_S;

    int            period;
    logic          tick_wrap;
    logic [TW-1:0] cnt_d;
    logic          step_fire;

    // Step period shrinks with each kill, floored at the minimum.
    always_comb begin
        period = PERIOD_MAX - int'(kills) * PERIOD_DEC;
        if (period < PERIOD_MIN) period = PERIOD_MIN;
    end

    assign tick_wrap = (int'(cnt_q) + 1) >= period;
    assign step_fire = bus.tick && tick_wrap;

    // Tick counter next value; only committed while marching.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.tick) cnt_d = tick_wrap ? '0 : cnt_q + TW'(1);
    end

    logic signed [10:0] step_x_d;
    logic [9:0]         step_y_d;
    logic               step_dir_d;

    // One march step: advance, or drop and reverse at an edge.
    always_comb begin
        step_x_d   = x_q;
        step_y_d   = y_q;
        step_dir_d = dir_q;
        if (!dir_q) begin
            if (can_right) begin
                step_x_d = x_q + $signed(11'(STEP_X));
            end else begin
                step_y_d   = y_q + 10'(STEP_Y);
                step_dir_d = 1'b1;
            end
        end else begin
            if (can_left) begin
                step_x_d = x_q - $signed(11'(STEP_X));
            end else begin
                step_y_d   = y_q + 10'(STEP_Y);
                step_dir_d = 1'b0;
            end
        end
    end

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [N-1:0]  hit_mask;

    // Lowest-index live alien whose half-open box holds the laser.
    always_comb begin
        pos_t bx;
        pos_t by;
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = N - 1; i >= 0; i--) begin
            bx = x12 + pos_t'((i % NB_COL) * PX);
            by = y12 + pos_t'((i / NB_COL) * PY);
            if (alive_q[i] &&
                lx12 >= bx && lx12 < bx + AW_S &&
                ly12 >= by && ly12 < by + AH_S) begin
                hit         = 1'b1;
                hit_idx     = IW'(i);
                hit_mask    = '0;
                hit_mask[i] = 1'b1;
            end
        end
    end

    // Game FSM with registered formation state and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            alive_q <= {N{1'b1}};
            x_q     <= 11'(X0);
            y_q     <= 10'(Y0);
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            kidx_q  <= '0;
            vic_q   <= 1'b0;
            def_q   <= 1'b0;
        end else begin
            kill_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_q <= S_MARCH;
                end
                S_MARCH: begin
                    if (!any_live) begin
                        vic_q   <= 1'b1;
                        state_q <= S_WON;
                    end else if (over_line) begin
                        def_q   <= 1'b1;
                        state_q <= S_LOST;
                    end else begin
                        cnt_q <= cnt_d;
                        if (step_fire) begin
                            x_q   <= step_x_d;
                            y_q   <= step_y_d;
                            dir_q <= step_dir_d;
                        end
                        if (bus.laser_valid && hit) begin
                            kill_q  <= 1'b1;
                            kidx_q  <= hit_idx;
                            alive_q <= alive_q & ~hit_mask;
                        end
                    end
                end
                S_WON, S_LOST: begin
                    state_q <= state_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.kill     = kill_q;
    assign bus.kill_idx = kidx_q;
    assign bus.alive    = alive_q;
    assign bus.x_alien  = x_q;
    assign bus.y_alien  = y_q;
    assign bus.dir_left = dir_q;
    assign bus.victory  = vic_q;
    assign bus.defeat   = def_q;

endmodule
